// File: rtl/fetch_stage_ifid_pkg.sv
// Core-wide fetch constants: datapath widths, PC step, bubble encoding and reset vector.
package fetch_stage_ifid_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INCR = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [ADDR_W-1:0]  RESET_PC  = 64'h0;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures pc/instr when enabled, loads a bubble on flush or reset.
module if_id_reg
  import fetch_stage_ifid_pkg::*;
#(
  parameter int unsigned         AW  = ADDR_W,
  parameter int unsigned         IW  = INSTR_W,
  parameter logic [INSTR_W-1:0]  NOP = NOP_INSTR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          flush,
  input  logic [AW-1:0] pc_in,
  input  logic [IW-1:0] instr_in,
  output logic [AW-1:0] if_id_pc,
  output logic [IW-1:0] if_id_instr,
  output logic          if_id_valid
);

  logic [AW-1:0] pc_q;
  logic [IW-1:0] instr_q;
  logic          valid_q;

  // Flush beats enable, so a redirect during a stall still inserts a bubble.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pc_q    <= '0;
      instr_q <= NOP[IW-1:0];
      valid_q <= 1'b0;
    end else if (en) begin
      pc_q    <= pc_in;
      instr_q <= instr_in;
      valid_q <= 1'b1;
    end
  end

  assign if_id_pc    = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_valid = valid_q;

endmodule

// File: rtl/fetch_stage_ifid.sv
// Instruction-fetch stage: PC register, next-PC selection, misalign flag, fetch counter and IF/ID.
module fetch_stage_ifid
  import fetch_stage_ifid_pkg::*;
#(
  parameter int unsigned              ADDR_W    = fetch_stage_ifid_pkg::ADDR_W,
  parameter int unsigned              INSTR_W   = fetch_stage_ifid_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]        RESET_PC  = fetch_stage_ifid_pkg::RESET_PC,
  parameter logic [INSTR_W-1:0]       NOP_INSTR = fetch_stage_ifid_pkg::NOP_INSTR,
  parameter int unsigned              CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  Inst_Address,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid,
  output logic               misalign_fault,
  output logic [CNT_W-1:0]   fetch_count
);

  localparam logic [ADDR_W-1:0] INCR = ADDR_W'(PC_INCR);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      pc_d = {redirect_target[ADDR_W-1:2], 2'b00};
      if (redirect_target[1:0] != 2'b00) fault_d = 1'b1;
    end else if (!stall) begin
      pc_d  = pc_q + INCR;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Inst_Address   = pc_q;
  assign misalign_fault = fault_q;
  assign fetch_count    = cnt_q;

  if_id_reg #(
    .AW  (ADDR_W),
    .IW  (INSTR_W),
    .NOP (NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .en          (!stall),
    .flush       (redirect),
    .pc_in       (pc_q),
    .instr_in    (Instruction),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage_ifid.sv
// Directed vector bench for the fetch stage with a small combinational instruction memory.
module tb_fetch_stage_ifid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] Inst_Address;
  logic [31:0] Instruction;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_target;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        misalign_fault;
  logic [31:0] fetch_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  fetch_stage_ifid #(
    .ADDR_W    (64),
    .INSTR_W   (32),
    .RESET_PC  (64'h0),
    .NOP_INSTR (32'h0000_0013),
    .CNT_W     (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .Inst_Address    (Inst_Address),
    .Instruction     (Instruction),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr),
    .if_id_valid     (if_id_valid),
    .misalign_fault  (misalign_fault),
    .fetch_count     (fetch_count)
  );

  function automatic logic [31:0] imem(input logic [63:0] a);
    case (a)
      64'h0:                   imem = 32'h0040_0293;
      64'h4:                   imem = 32'h0002_01B3;
      64'h8:                   imem = 32'h00A0_0313;
      64'h40:                  imem = 32'h0010_0093;
      64'h100:                 imem = 32'h0020_8133;
      64'hFFFF_FFFF_FFFF_FFFC: imem = 32'h0000_006F;
      default:                 imem = 32'hC000_0000 | a[31:0];
    endcase
  endfunction

  assign Instruction = imem(Inst_Address);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdr;
    logic [63:0] tgt;
    logic [63:0] e_addr;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_fault;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t v[20];

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;

    //        rst   stl   rdr   target                  addr                    if_id_pc                instr          vld   flt   cnt
    v[0]  = '{1'b1, 1'b0, 1'b0, 64'h0,                  64'h0,                  64'h0,                  NOP,           1'b0, 1'b0, 32'd0};
    v[1]  = '{1'b0, 1'b0, 1'b0, 64'h0,                  64'h4,                  64'h0,                  32'h0040_0293, 1'b1, 1'b0, 32'd1};
    v[2]  = '{1'b0, 1'b0, 1'b0, 64'h0,                  64'h8,                  64'h4,                  32'h0002_01B3, 1'b1, 1'b0, 32'd2};
    v[3]  = '{1'b1, 1'b0, 1'b0, 64'h0,                  64'h0,                  64'h0,                  NOP,           1'b0, 1'b0, 32'd0};
    v[4]  = '{1'b0, 1'b0, 1'b0, 64'h0,                  64'h4,                  64'h0,                  32'h0040_0293, 1'b1, 1'b0, 32'd1};
    v[5]  = '{1'b0, 1'b1, 1'b0, 64'h0,                  64'h4,                  64'h0,                  32'h0040_0293, 1'b1, 1'b0, 32'd1};
    v[6]  = '{1'b0, 1'b1, 1'b0, 64'h0,                  64'h4,                  64'h0,                  32'h0040_0293, 1'b1, 1'b0, 32'd1};
    v[7]  = '{1'b0, 1'b1, 1'b0, 64'h0,                  64'h4,                  64'h0,                  32'h0040_0293, 1'b1, 1'b0, 32'd1};
    v[8]  = '{1'b0, 1'b0, 1'b0, 64'h0,                  64'h8,                  64'h4,                  32'h0002_01B3, 1'b1, 1'b0, 32'd2};
    v[9]  = '{1'b0, 1'b1, 1'b1, 64'h40,                 64'h40,                 64'h0,                  NOP,           1'b0, 1'b0, 32'd2};
    v[10] = '{1'b0, 1'b0, 1'b0, 64'h0,                  64'h44,                 64'h40,                 32'h0010_0093, 1'b1, 1'b0, 32'd3};
    v[11] = '{1'b0, 1'b0, 1'b1, 64'h42,                 64'h40,                 64'h0,                  NOP,           1'b0, 1'b1, 32'd3};
    v[12] = '{1'b0, 1'b0, 1'b1, 64'h100,                64'h100,                64'h0,                  NOP,           1'b0, 1'b1, 32'd3};
    v[13] = '{1'b0, 1'b1, 1'b0, 64'h0,                  64'h100,                64'h0,                  NOP,           1'b0, 1'b1, 32'd3};
    v[14] = '{1'b0, 1'b0, 1'b0, 64'h0,                  64'h104,                64'h100,                32'h0020_8133, 1'b1, 1'b1, 32'd4};
    v[15] = '{1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0,                 NOP,           1'b0, 1'b1, 32'd4};
    v[16] = '{1'b0, 1'b0, 1'b0, 64'h0,                  64'h0,                  64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_006F, 1'b1, 1'b1, 32'd5};
    v[17] = '{1'b1, 1'b1, 1'b1, 64'h80,                 64'h0,                  64'h0,                  NOP,           1'b0, 1'b0, 32'd0};
    v[18] = '{1'b0, 1'b0, 1'b0, 64'h0,                  64'h4,                  64'h0,                  32'h0040_0293, 1'b1, 1'b0, 32'd1};
    v[19] = '{1'b0, 1'b0, 1'b1, 64'h7,                  64'h4,                  64'h0,                  NOP,           1'b0, 1'b1, 32'd1};

    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      reset = v[i].rst; stall = v[i].stl; redirect = v[i].rdr; redirect_target = v[i].tgt;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d addr", i),  Inst_Address,   v[i].e_addr);
      chk($sformatf("v%0d pc", i),    if_id_pc,       v[i].e_pc);
      chk($sformatf("v%0d instr", i), {32'h0, if_id_instr}, {32'h0, v[i].e_instr});
      chk($sformatf("v%0d valid", i), {63'h0, if_id_valid}, {63'h0, v[i].e_valid});
      chk($sformatf("v%0d fault", i), {63'h0, misalign_fault}, {63'h0, v[i].e_fault});
      chk($sformatf("v%0d cnt", i),   {32'h0, fetch_count}, {32'h0, v[i].e_cnt});
    end

    // Inst_Address reflects only the PC register: redirect/stall inputs must not leak through mid-cycle.
    @(negedge clk);
    reset = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_target = 64'h200;
    #1;
    chk("comb addr", Inst_Address, 64'h4);

    // Free-running advance from 0x200: each edge captures the previous PC and its instruction.
    @(posedge clk); #1;
    chk("seq redirect addr", Inst_Address, 64'h200);
    @(negedge clk);
    stall = 1'b0; redirect = 1'b0;
    for (int unsigned k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("seq%0d pc", k),    if_id_pc, 64'h200 + 64'(4 * k));
      chk($sformatf("seq%0d instr", k), {32'h0, if_id_instr}, {32'h0, 32'hC000_0200 + 32'(4 * k)});
      chk($sformatf("seq%0d addr", k),  Inst_Address, 64'h204 + 64'(4 * k));
      chk($sformatf("seq%0d cnt", k),   {32'h0, fetch_count}, 64'(2 + k));
    end
    chk("seq fault sticky", {63'h0, misalign_fault}, 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
